// File: rtl/controlador_estados_param.sv
// controlador_estados_param: pet state controller (IDLE/COMENDO/DORMINDO/
// DANDO_AULA/MORTO) with three saturating need counters, an internal
// per-second tick divider and registered button edge detection.
// Optional feature: define ALERTA_EN to enable the low-need warning output.
// Ports:
//   clk, rst        - single clock, synchronous active-high reset
//   b1, b2          - debounced button levels
//   estado          - 000 IDLE, 001 COMENDO, 010 DORMINDO, 011 DANDO_AULA, 100 MORTO
//   fome, sono, felicidade - need levels (NEED_W bits)
//   tick_seg        - one-cycle pulse per game second
//   alerta          - low-need warning (constant 0 without ALERTA_EN)
module controlador_estados_param #(
  parameter int unsigned NEED_W        = 8,
  parameter int unsigned NEED_MAX      = 100,
  parameter int unsigned NEED_INIT     = 50,
  parameter int unsigned TICKS_PER_SEC = 100,
  parameter int unsigned INC           = 5,
  parameter int unsigned DEC           = 1,
  parameter int unsigned ALERT_LEVEL   = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              b1,
  input  logic              b2,
  output logic [2:0]        estado,
  output logic [NEED_W-1:0] fome,
  output logic [NEED_W-1:0] sono,
  output logic [NEED_W-1:0] felicidade,
  output logic              tick_seg,
  output logic              alerta
);

  localparam int unsigned CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned NW1   = NEED_W + 1;

  // Elaboration-time sanity check of the configuration.
  if ((NEED_MAX >= (2 ** NEED_W)) || (ALERT_LEVEL > NEED_MAX)) begin : g_bad_cfg
    $error("controlador_estados_param: invalid NEED_MAX/ALERT_LEVEL for NEED_W");
  end

  typedef enum logic [2:0] {
    IDLE       = 3'b000,
    COMENDO    = 3'b001,
    DORMINDO   = 3'b010,
    DANDO_AULA = 3'b011,
    MORTO      = 3'b100
  } estado_e;

  estado_e           estado_q, estado_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tick_q, tick_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [1:0]        prev_q, prev_d;
  logic [NEED_W-1:0] fome_q, fome_d;
  logic [NEED_W-1:0] sono_q, sono_d;
  logic [NEED_W-1:0] feli_q, feli_d;
  logic              alerta_q, alerta_d;
  logic              tick_c;
  logic              evento_c;

  // Saturating increment, one extra bit so the sum can never wrap.
  function automatic logic [NEED_W-1:0] sat_inc(input logic [NEED_W-1:0] v);
    logic [NEED_W:0] s;
    s = {1'b0, v} + NW1'(INC);
    if (s > NW1'(NEED_MAX)) s = NW1'(NEED_MAX);
    return NEED_W'(s);
  endfunction

  // Saturating decrement, floors at zero.
  function automatic logic [NEED_W-1:0] sat_dec(input logic [NEED_W-1:0] v);
    logic [NEED_W:0] s;
    if ({1'b0, v} < NW1'(DEC)) s = '0;
    else                       s = {1'b0, v} - NW1'(DEC);
    return NEED_W'(s);
  endfunction

  // Next-state, need update and divider logic.
  always_comb begin
    estado_d = estado_q;
    fome_d   = fome_q;
    sono_d   = sono_q;
    feli_d   = feli_q;
    alerta_d = 1'b0;

    tick_c   = (cnt_q == CNT_W'(TICKS_PER_SEC - 1));
    evento_c = (cmd_q != 2'b00) && (prev_q == 2'b00);
    cnt_d    = tick_c ? '0 : cnt_q + CNT_W'(1);
    tick_d   = tick_c;
    cmd_d    = {b1, b2};
    prev_d   = cmd_q;

    if (estado_q != MORTO) begin
      // Needs are updated with the state held before any transition.
      if (tick_c) begin
        fome_d = (estado_q == COMENDO)    ? sat_inc(fome_q) : sat_dec(fome_q);
        sono_d = (estado_q == DORMINDO)   ? sat_inc(sono_q) : sat_dec(sono_q);
        feli_d = (estado_q == DANDO_AULA) ? sat_inc(feli_q) : sat_dec(feli_q);
      end
      // Death wins over a simultaneous button transition.
      if (tick_c && ((fome_d == '0) || (sono_d == '0) || (feli_d == '0))) begin
        estado_d = MORTO;
      end else if (evento_c) begin
        case (estado_q)
          IDLE: begin
            case (cmd_q)
              2'b10:   estado_d = COMENDO;
              2'b01:   estado_d = DORMINDO;
              2'b11:   estado_d = DANDO_AULA;
              default: estado_d = IDLE;
            endcase
          end
          COMENDO:    if (cmd_q == 2'b10) estado_d = IDLE;
          DORMINDO:   if (cmd_q == 2'b01) estado_d = IDLE;
          DANDO_AULA: if (cmd_q == 2'b11) estado_d = IDLE;
          default:    estado_d = estado_q;
        endcase
      end
    end

`ifdef ALERTA_EN
    alerta_d = (estado_d != MORTO) &&
               ((fome_d <= NEED_W'(ALERT_LEVEL)) ||
                (sono_d <= NEED_W'(ALERT_LEVEL)) ||
                (feli_d <= NEED_W'(ALERT_LEVEL)));
`else
    alerta_d = 1'b0;
`endif
  end

  // State registers; history forced to 11 so a held button is not an event.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= IDLE;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      cmd_q    <= 2'b11;
      prev_q   <= 2'b11;
      fome_q   <= NEED_W'(NEED_INIT);
      sono_q   <= NEED_W'(NEED_INIT);
      feli_q   <= NEED_W'(NEED_INIT);
      alerta_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      cmd_q    <= cmd_d;
      prev_q   <= prev_d;
      fome_q   <= fome_d;
      sono_q   <= sono_d;
      feli_q   <= feli_d;
      alerta_q <= alerta_d;
    end
  end

  assign estado     = estado_q;
  assign fome       = fome_q;
  assign sono       = sono_q;
  assign felicidade = feli_q;
  assign tick_seg   = tick_q;
  assign alerta     = alerta_q;

endmodule

// File: tb/tb_controlador_estados_param.sv
// Directed bench for controlador_estados_param: two instances (NEED_INIT 50
// and 98) with a 4-cycle game second; expected values are hand-computed.
module tb_controlador_estados_param;

`ifdef ALERTA_EN
  localparam logic AL_EN = 1'b1;
`else
  localparam logic AL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, b1, b2;
  logic       rst2, b1_2, b2_2;
  logic [2:0] estado, estado2;
  logic [7:0] fome, sono, feli, fome2, sono2, feli2;
  logic       tick_seg, alerta, tick_seg2, alerta2;

  int checks   = 0;
  int failures = 0;

  controlador_estados_param #(
    .NEED_W(8), .NEED_MAX(100), .NEED_INIT(50), .TICKS_PER_SEC(4),
    .INC(5), .DEC(1), .ALERT_LEVEL(20)
  ) dut (
    .clk(clk), .rst(rst), .b1(b1), .b2(b2), .estado(estado),
    .fome(fome), .sono(sono), .felicidade(feli),
    .tick_seg(tick_seg), .alerta(alerta)
  );

  controlador_estados_param #(
    .NEED_W(8), .NEED_MAX(100), .NEED_INIT(98), .TICKS_PER_SEC(4),
    .INC(5), .DEC(1), .ALERT_LEVEL(20)
  ) dut98 (
    .clk(clk), .rst(rst2), .b1(b1_2), .b2(b2_2), .estado(estado2),
    .fome(fome2), .sono(sono2), .felicidade(feli2),
    .tick_seg(tick_seg2), .alerta(alerta2)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; b1 = 1'b0; b2 = 1'b0;
    rst2 = 1'b1; b1_2 = 1'b0; b2_2 = 1'b0;

    // 1: reset, then three idle ticks
    step(2);
    rst = 1'b0;
    chk("rst_estado", 32'(estado), 32'd0);
    chk("rst_fome", 32'(fome), 32'd50);
    chk("rst_sono", 32'(sono), 32'd50);
    chk("rst_feli", 32'(feli), 32'd50);
    chk("rst_tick", 32'(tick_seg), 32'd0);
    chk("rst_alerta", 32'(alerta), 32'd0);
    step(3);
    chk("t1_no_tick_c3", 32'(tick_seg), 32'd0);
    step(1);
    chk("t1_tick_c4", 32'(tick_seg), 32'd1);
    chk("t1_fome_49", 32'(fome), 32'd49);
    step(1);
    chk("t1_tick_low", 32'(tick_seg), 32'd0);
    step(7);
    chk("t1_tick_c12", 32'(tick_seg), 32'd1);
    chk("t1_fome_47", 32'(fome), 32'd47);
    chk("t1_sono_47", 32'(sono), 32'd47);
    chk("t1_feli_47", 32'(feli), 32'd47);

    // 2: feed
    b1 = 1'b1;
    step(1);
    b1 = 1'b0;
    chk("t2_lat1", 32'(estado), 32'd0);
    step(1);
    chk("t2_comendo", 32'(estado), 32'd1);
    step(10);
    chk("t2_fome_62", 32'(fome), 32'd62);
    chk("t2_sono_44", 32'(sono), 32'd44);
    chk("t2_feli_44", 32'(feli), 32'd44);
    b1 = 1'b1;
    step(1);
    b1 = 1'b0;
    step(1);
    chk("t2_back_idle", 32'(estado), 32'd0);

    // 4/6: idle to death, alerta, frozen in MORTO, reset exit
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(116);
    chk("t4_fome_21", 32'(fome), 32'd21);
    chk("t6_alerta_21", 32'(alerta), 32'd0);
    step(4);
    chk("t4_sono_20", 32'(sono), 32'd20);
    chk("t6_alerta_20", 32'(alerta), 32'(AL_EN));
    step(76);
    chk("t4_fome_1", 32'(fome), 32'd1);
    chk("t4_alive", 32'(estado), 32'd0);
    chk("t6_alerta_1", 32'(alerta), 32'(AL_EN));
    step(4);
    chk("t4_morto", 32'(estado), 32'd4);
    chk("t4_fome_0", 32'(fome), 32'd0);
    chk("t4_feli_0", 32'(feli), 32'd0);
    chk("t6_alerta_dead", 32'(alerta), 32'd0);
    b1 = 1'b1; step(2); b1 = 1'b0; step(2);
    b2 = 1'b1; step(2); b2 = 1'b0; step(2);
    b1 = 1'b1; b2 = 1'b1; step(2); b1 = 1'b0; b2 = 1'b0; step(4);
    chk("t4_still_morto", 32'(estado), 32'd4);
    chk("t4_sono_frozen", 32'(sono), 32'd0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("t4_rst_estado", 32'(estado), 32'd0);
    chk("t4_rst_fome", 32'(fome), 32'd50);

    // 5: buttons held through reset, then event coinciding with a tick
    rst = 1'b1; b1 = 1'b1; b2 = 1'b1;
    step(2);
    rst = 1'b0;
    step(4);
    chk("t5_held_no_evt", 32'(estado), 32'd0);
    chk("t5_fome_49", 32'(fome), 32'd49);
    b1 = 1'b0; b2 = 1'b0;
    step(2);
    b1 = 1'b1; b2 = 1'b1;
    step(1);
    chk("t5_pre_evt", 32'(estado), 32'd0);
    step(1);
    b1 = 1'b0; b2 = 1'b0;
    chk("t5_aula", 32'(estado), 32'd3);
    chk("t5_fome_48", 32'(fome), 32'd48);
    chk("t5_feli_48", 32'(feli), 32'd48);
    step(4);
    chk("t5_feli_53", 32'(feli), 32'd53);
    chk("t5_sono_47", 32'(sono), 32'd47);

    // 3: saturation at NEED_MAX on the 98-init instance
    rst2 = 1'b0;
    step(1);
    b2_2 = 1'b1;
    step(1);
    b2_2 = 1'b0;
    step(1);
    chk("t3_dormindo", 32'(estado2), 32'd2);
    step(1);
    chk("t3_tick", 32'(tick_seg2), 32'd1);
    chk("t3_sono_100", 32'(sono2), 32'd100);
    chk("t3_fome_97", 32'(fome2), 32'd97);
    chk("t3_feli_97", 32'(feli2), 32'd97);
    chk("t3_alerta", 32'(alerta2), 32'd0);
    step(4);
    chk("t3_sono_sat", 32'(sono2), 32'd100);
    chk("t3_fome_96", 32'(fome2), 32'd96);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
